// File: rtl/code_run_length_encoder_pkg.sv
// Shared types and helpers for the run-length encoder slice.
package code_run_length_encoder_pkg;

  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rle_state_t;

  // Longest run a CW-bit counter can represent; longer runs are split.
  function automatic int max_run(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/code_run_length_encoder_out_slot.sv
// One-entry valid/ready output register holding a single (code, count) token.
module rle_out_slot #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         can_load
);

  // A load may overwrite a token only in the cycle that token is consumed.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/code_run_length_encoder.sv
// Collapses runs of identical 2-bit codes into (code, run length) tokens.
module code_run_length_encoder
  import code_run_length_encoder_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [CW-1:0]     out_count,
  input  logic              out_ready
);

  localparam logic [CW-1:0] MAXRUN = CW'(max_run(CW));

  rle_state_t          state, state_next;
  logic [CODE_W-1:0]   run_code, run_code_next;
  logic [CW-1:0]       run_cnt, run_cnt_next;
  logic                flush_done_next;
  logic                load;
  logic                can_load;
  logic                accept;
  logic [CODE_W+CW-1:0] slot_data;

  assign in_ready = !reset && !flush && can_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      run_code   <= '0;
      run_cnt    <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      run_code   <= run_code_next;
      run_cnt    <= run_cnt_next;
      flush_done <= flush_done_next;
    end
  end

  // Any token loaded is always the currently open run; only the trigger differs.
  always_comb begin
    state_next      = state;
    run_code_next   = run_code;
    run_cnt_next    = run_cnt;
    flush_done_next = 1'b0;
    load            = 1'b0;
    if (flush) begin
      if (state == IDLE) begin
        flush_done_next = 1'b1;
      end else if (can_load) begin
        load            = 1'b1;
        state_next      = IDLE;
        run_cnt_next    = '0;
        flush_done_next = 1'b1;
      end
    end else if (accept) begin
      if (state == IDLE) begin
        state_next    = RUN;
        run_code_next = in_code;
        run_cnt_next  = CW'(1);
      end else if (in_code == run_code && run_cnt < MAXRUN) begin
        run_cnt_next = run_cnt + CW'(1);
      end else begin
        load          = 1'b1;
        run_code_next = in_code;
        run_cnt_next  = CW'(1);
      end
    end
  end

  rle_out_slot #(
    .W(CODE_W + CW)
  ) u_out_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .data      ({run_code, run_cnt}),
    .out_valid (out_valid),
    .out_data  (slot_data),
    .out_ready (out_ready),
    .can_load  (can_load)
  );

  assign out_code  = slot_data[CODE_W+CW-1:CW];
  assign out_count = slot_data[CW-1:0];

endmodule

// File: tb/tb_code_run_length_encoder.sv
// Directed bench for code_run_length_encoder: vector table plus corner-case sequences.
module tb_code_run_length_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic       flush;
  logic       flush_done;
  logic       out_valid;
  logic [1:0] out_code;
  logic [3:0] out_count;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       f;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [1:0] e_code;
    logic [3:0] e_cnt;
    logic       e_fd;
  } vec_t;

  vec_t vecs[12];

  code_run_length_encoder #(.CW(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .out_count  (out_count),
    .out_ready  (out_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic f,
                               input logic ordy, input logic rst);
    in_valid  = v;
    in_code   = c;
    flush     = f;
    out_ready = ordy;
    reset     = rst;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Registered outputs after the edge; code/count checked only when a token is expected.
  task automatic checkAfter(input string tag, input logic e_ov, input logic [1:0] e_code,
                            input logic [3:0] e_cnt, input logic e_fd);
    checkOutput({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
    checkOutput({tag, ".flush_done"}, int'(flush_done), int'(e_fd));
    if (e_ov) begin
      checkOutput({tag, ".out_code"}, int'(out_code), int'(e_code));
      checkOutput({tag, ".out_count"}, int'(out_count), int'(e_cnt));
    end
  endtask

  task automatic runVec(input vec_t t, input string tag);
    applyStimulus(t.v, t.c, t.f, t.ordy, 1'b0);
    #2;
    checkOutput({tag, ".in_ready"}, int'(in_ready), int'(t.e_rdy));
    tick();
    checkAfter(tag, t.e_ov, t.e_code, t.e_cnt, t.e_fd);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // v, c, f, ordy | rdy, ov, code, cnt, fd
    vecs[0]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'd3, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd1, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'd1, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd1, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};

    // Reset values, including in_ready gated low by reset.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("rst.in_ready", int'(in_ready), 0);
    checkOutput("rst.out_valid", int'(out_valid), 0);
    checkOutput("rst.flush_done", int'(flush_done), 0);
    checkOutput("rst.out_code", int'(out_code), 0);
    checkOutput("rst.out_count", int'(out_count), 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Basic runs/flush and alternating full-throughput codes.
    for (int i = 0; i < 12; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // 17 identical codes: saturation splits into (3,15) then (3,2).
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("sat%0d.out_valid", i), int'(out_valid), (i == 15) ? 1 : 0);
      if (out_valid) checkOutput($sformatf("sat%0d.nonzero", i), int'(out_count != 0), 1);
    end
    checkOutput("sat.tok_code", int'(out_code), 3);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkAfter("sat.flush", 1'b1, 2'd3, 4'd2, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("sat.idle", 1'b0, 2'd0, 4'd0, 1'b0);

    // Backpressure: token (0,1) held stable, in_ready low, nothing lost.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("bp.first", 1'b1, 2'd0, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput($sformatf("bp%0d.in_ready", i), int'(in_ready), 0);
      tick();
      checkAfter($sformatf("bp%0d", i), 1'b1, 2'd0, 4'd1, 1'b0);
    end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("bp.release.in_ready", int'(in_ready), 1);
    tick();
    checkAfter("bp.release", 1'b1, 2'd1, 4'd1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkAfter("bp.flush", 1'b1, 2'd2, 4'd1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("bp.idle", 1'b0, 2'd0, 4'd0, 1'b0);

    // Reset mid-run with a blocked token: both run and token discarded.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("mr.token", 1'b1, 2'd1, 4'd4, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("mr.out_valid", int'(out_valid), 0);
    checkOutput("mr.out_count", int'(out_count), 0);
    checkOutput("mr.flush_done", int'(flush_done), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("mr.code3", 1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkAfter("mr.flush", 1'b1, 2'd3, 4'd1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("mr.idle", 1'b0, 2'd0, 4'd0, 1'b0);

    // Flush in IDLE with in_valid held: pulses flush_done, accepts nothing.
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("if.in_ready", int'(in_ready), 0);
    tick();
    checkAfter("if.first", 1'b0, 2'd0, 4'd0, 1'b1);
    tick();
    checkAfter("if.held", 1'b0, 2'd0, 4'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkAfter("if.drop", 1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkAfter("if.noRun", 1'b0, 2'd0, 4'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();

    doReset();
    tick();
    checkOutput("end.out_valid", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
